// File: rtl/dma_channel_arbiter.sv
// ---------------------------------------------------------------------------
// dma_channel_arbiter
//   Two-channel DMA controller for the I/O-to-RAM path. Block-transfer
//   requests from device 0 and device 1 are arbitrated round-robin. The
//   memory bus is borrowed from the processor with holdReq/holdAck. One
//   DATA_W word moves per cycle between the granted device and RAM. The bus
//   is released when the block is done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   dreq[1:0]           per-channel request level (bit0 = dev0, bit1 = dev1)
//   drw[1:0]            per-channel direction (0 = device->RAM, 1 = RAM->device)
//   dbase0/1, dlen0/1   start address and word count, sampled at grant
//   dwdata0/1           device write data, advanced by the device on its dstrobe
//   drdata              read data to the device (mirrors ram_rdata)
//   dstrobe[1:0]        one-hot: a word for that channel moves this cycle
//   ddone[1:0]          one-cycle completion pulse per channel
//   holdReq / holdAck   bus request to / grant from the processor
//   ram_en, ramCtrl     RAM access strobe and direction (1 = write)
//   ram_addr            RAM word address
//   ram_wdata           write data of the granted channel
//   ram_rdata           RAM read data, combinational in the same cycle
// ---------------------------------------------------------------------------
module dma_channel_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dreq,
  input  logic [1:0]        drw,
  input  logic [ADDR_W-1:0] dbase0,
  input  logic [ADDR_W-1:0] dbase1,
  input  logic [LEN_W-1:0]  dlen0,
  input  logic [LEN_W-1:0]  dlen1,
  input  logic [DATA_W-1:0] dwdata0,
  input  logic [DATA_W-1:0] dwdata1,
  output logic [DATA_W-1:0] drdata,
  output logic [1:0]        dstrobe,
  output logic [1:0]        ddone,
  output logic              holdReq,
  input  logic              holdAck,
  output logic              ram_en,
  output logic              ramCtrl,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ch_q, ch_d;         // granted channel
  logic                rr_q, rr_d;         // channel preferred when both request
  logic                drw_q, drw_d;       // latched direction of granted channel
  logic [ADDR_W-1:0]   cur_q, cur_d;       // current RAM address
  logic [LEN_W-1:0]    rem_q, rem_d;       // words still to move
  logic                hold_req_q, hold_req_d;
  logic [1:0]          ddone_q, ddone_d;

  logic                req_ch;
  logic [LEN_W-1:0]    req_len;
  logic                beat;

  // A single requester always wins; contention is settled by the rr pointer.
  assign req_ch  = (dreq == 2'b11) ? rr_q : dreq[1];
  assign req_len = req_ch ? dlen1 : dlen0;

  // A beat happens in any XFER cycle where the processor still grants the bus;
  // holdAck low simply stalls with address and count frozen.
  assign beat = (state_q == XFER) && holdAck;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    drw_d      = drw_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    hold_req_d = hold_req_q;
    ddone_d    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|dreq) begin
          ch_d  = req_ch;
          drw_d = drw[req_ch];
          if (req_len == '0) begin
            // Empty transfer completes without touching the bus.
            ddone_d = req_ch ? 2'b10 : 2'b01;
            rr_d    = ~req_ch;
          end else begin
            cur_d      = req_ch ? dbase1 : dbase0;
            rem_d      = req_len;
            hold_req_d = 1'b1;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        if (holdAck) begin
          state_d = XFER;
        end
      end

      XFER: begin
        if (holdAck) begin
          cur_d = cur_q + ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d    = REL;
            hold_req_d = 1'b0;
            ddone_d    = ch_q ? 2'b10 : 2'b01;
            rr_d       = ~ch_q;
          end
        end
      end

      REL: begin
        // Do not re-arbitrate until the processor has taken the bus back.
        if (!holdAck) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= 1'b0;
      rr_q       <= 1'b0;
      drw_q      <= 1'b0;
      cur_q      <= '0;
      rem_q      <= '0;
      hold_req_q <= 1'b0;
      ddone_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      drw_q      <= drw_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      hold_req_q <= hold_req_d;
      ddone_q    <= ddone_d;
    end
  end

  assign holdReq   = hold_req_q;
  assign ddone     = ddone_q;
  assign ram_en    = beat;
  assign ramCtrl   = beat & ~drw_q;
  assign ram_addr  = cur_q;
  assign dstrobe   = beat ? {ch_q, ~ch_q} : 2'b00;
  assign ram_wdata = ch_q ? dwdata1 : dwdata0;
  assign drdata    = ram_rdata;

endmodule
